// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//   Shared definitions for the program loader: FSM state encoding and the
//   byte-framing constants of the load protocol.
//   Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  // Load protocol framing
  localparam int LEN_BYTES      = 2;  // word-count header, MSB first
  localparam int BYTES_PER_WORD = 4;  // big-endian packing into 32-bit words

  // FSM state encoding (3 bits)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHK    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LEN_HI = ST_LEN_HI,
    LEN_LO = ST_LEN_LO,
    DATA   = ST_DATA,
    WRITE  = ST_WRITE,
    DONE   = ST_DONE,
    ERROR  = ST_ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHK  = ST_CHK
`endif
  } state_t;

endpackage

// File: rtl/prog_loader_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Packs accepted bytes big-endian into a 32-bit word: the first byte of a
//   word ends up in bits 31:24. A 2-bit counter tracks the byte position.
//   Ports:
//     reloj, resetM  clock / async active-low reset
//     shift_en       a byte is accepted this cycle
//     clear          restart the byte counter and drop word_full
//     byte_in        incoming byte
//     word           packed word (held stable until the next shift)
//     last_byte      the next accepted byte completes the word
//     word_full      high for the cycle after the 4th byte of a word
// -----------------------------------------------------------------------------
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        reloj,
  input  logic        resetM,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte,
  output logic        word_full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt;

  assign last_byte = (cnt == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      word      <= '0;
      cnt       <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      word_full <= 1'b0;
    end else if (shift_en) begin
      // Shifting left leaves byte 0 of the word in the top lane after 4 bytes.
      word <= {word[23:0], byte_in};
      cnt  <= cnt + 1'b1;  // wraps to 0 after the last byte
      if (last_byte) word_full <= 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Loads a program image from a byte stream into the instruction memory and
//   holds the core in reset until a complete, valid image is in place.
//   Stream: 16-bit word count N (MSB first), then 4*N data bytes packed
//   big-endian, then (LOADER_CHECKSUM_EN only) one XOR checksum byte.
//   Optional feature macro: LOADER_CHECKSUM_EN.
//   Ports:
//     reloj, resetM        clock / async active-low reset
//     start                one-cycle pulse, begins a session when not busy
//     rx_data/rx_valid     byte stream in; transfer on rx_valid && rx_ready
//     rx_ready             loader accepts a byte
//     im_we/im_addr/im_data instruction-memory write port, one strobe per word
//     cpu_resetM           core reset, released only in DONE
//     busy/done/error      session status
//     words_loaded         words written in the current session
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_WORDS = 128
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic              cpu_resetM,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LEN_W = LEN_BYTES * 8;

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_full;
  logic             len_ok;
  logic             last_word;
  logic [ADDR_W:0]  wl_q;
  logic             xfer;
  logic             restart;
  logic             last_byte;
  logic             word_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       xor_q;
`endif

  assign xfer    = rx_valid && rx_ready;
  // A new session may only begin from a resting state; start is ignored while busy.
  assign restart = start && (state == IDLE || state == DONE || state == ERROR);

  // Complete count as it will look once the LEN_LO byte lands.
  assign len_full  = {len_q[LEN_W-9:0], rx_data};
  assign len_ok    = (len_full != '0) && (len_full <= LEN_W'(MAX_WORDS));
  // Evaluated in WRITE, before words_loaded takes its increment.
  assign last_word = ((LEN_W'(wl_q) + LEN_W'(1)) == len_q);

  byte_packer u_packer (
    .reloj     (reloj),
    .resetM    (resetM),
    .shift_en  (xfer && state == DATA),
    .clear     (state == WRITE || restart),
    .byte_in   (rx_data),
    .word      (im_data),
    .last_byte (last_byte),
    .word_full (word_full)
  );

  // word_full is set by the 4th byte and cleared by WRITE, so it spans
  // exactly the WRITE cycle.
  assign im_we        = word_full;
  assign im_addr      = wl_q[ADDR_W-1:0];
  assign words_loaded = wl_q;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state <= IDLE;
      len_q <= '0;
      wl_q  <= '0;
    end else begin
      state <= state_nx;
      if (xfer && (state == LEN_HI || state == LEN_LO))
        len_q <= len_full;
      if (restart)
        wl_q <= '0;
      else if (state == WRITE)
        wl_q <= wl_q + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM)
      xor_q <= '0;
    else if (restart)
      xor_q <= '0;
    else if (xfer && state == DATA)
      xor_q <= xor_q ^ rx_data;
  end
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_resetM = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = len_ok ? DATA : ERROR;
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && last_byte) state_nx = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_nx = last_word ? CHK : DATA;
`else
        state_nx = last_word ? DONE : DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = (rx_data == xor_q) ? DONE : ERROR;
      end
`endif
      DONE: begin
        done       = 1'b1;
        cpu_resetM = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
